serial_tx: RTL and testbench

Parallel-in, serial-out frame transmitter. It is the sending end of the single-wire serial link whose receive side samples one bit per clock through the D-flip-flop stage. A byte is accepted on a valid/ready handshake, then shifted out one bit per clock as: start bit, data LSB first, optional parity bit, stop bit. The line idles high, which is the preset level.

---
 rtl/serial_pkg.sv | 20 ++
 rtl/serial_tx_piso_reg.sv | 27 ++
 rtl/serial_tx.sv | 116 +++++++++++
 tb/tb_serial_tx.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/serial_pkg.sv
// Shared definitions for the single-wire serial link (transmit and receive ends).
package serial_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    DATA  = 3'd2,
    PAR   = 3'd3,
    STOP  = 3'd4
  } tx_state_t;

  localparam int PAR_NONE = 0;
  localparam int PAR_EVEN = 1;
  localparam int PAR_ODD  = 2;

  localparam logic LINE_IDLE = 1'b1;
  localparam logic START_BIT = 1'b0;
  localparam logic STOP_BIT  = 1'b1;

endpackage

// File: rtl/serial_tx_piso_reg.sv
// Parallel-in, serial-out shift register: synchronous load, right shift, bit 0 is the serial output.
module piso_reg #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             load,
  input  logic             shift,
  input  logic [WIDTH-1:0] din,
  output logic             ser
);

  logic [WIDTH-1:0] q;

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      q <= '0;
    end else if (load) begin
      q <= din;
    end else if (shift) begin
      q <= {1'b0, q[WIDTH-1:1]};
    end
  end

  assign ser = q[0];

endmodule

// File: rtl/serial_tx.sv
// Frame transmitter: start bit, WIDTH data bits LSB first, optional parity bit, stop bit.
module serial_tx
  import serial_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int PARITY = 0
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             load_valid,
  output logic             load_ready,
  input  logic [WIDTH-1:0] data_in,
  output logic             sout,
  output logic             busy,
  output logic             done
);

  if (WIDTH < 2 || PARITY < 0 || PARITY > 2) begin : g_bad_param
    $error("serial_tx: WIDTH must be >= 2 and PARITY must be 0, 1 or 2");
  end

  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);
  localparam bit HAS_PAR = (PARITY != PAR_NONE);

  function automatic logic parity_of(input logic [WIDTH-1:0] w);
    if (PARITY == PAR_ODD) begin
      return ~^w;
    end
    return ^w;
  endfunction

  tx_state_t        state_q, state_d;
  logic [CNT_W-1:0] cnt_q;
  logic             par_q;
  logic             sout_q, sout_d;
  logic             load, shift, ser;

  piso_reg #(.WIDTH(WIDTH)) u_piso (
    .clk   (clk),
    .clr   (clr),
    .load  (load),
    .shift (shift),
    .din   (data_in),
    .ser   (ser)
  );

  // sout is registered, so each branch sets the level for the state being entered.
  // The shifter moves on every edge that leaves a bit on the line, keeping ser one bit ahead.
  always_comb begin
    state_d = state_q;
    sout_d  = LINE_IDLE;
    load    = 1'b0;
    shift   = 1'b0;
    case (state_q)
      IDLE: begin
        if (load_valid) begin
          load    = 1'b1;
          state_d = START;
          sout_d  = START_BIT;
        end
      end
      START: begin
        state_d = DATA;
        sout_d  = ser;
        shift   = 1'b1;
      end
      DATA: begin
        if (cnt_q == LAST) begin
          state_d = HAS_PAR ? PAR : STOP;
          sout_d  = HAS_PAR ? par_q : STOP_BIT;
        end else begin
          sout_d = ser;
          shift  = 1'b1;
        end
      end
      PAR: begin
        state_d = STOP;
        sout_d  = STOP_BIT;
      end
      STOP: begin
        state_d = IDLE;
        sout_d  = LINE_IDLE;
      end
      default: begin
        state_d = IDLE;
        sout_d  = LINE_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state_q <= IDLE;
      sout_q  <= LINE_IDLE;
      cnt_q   <= '0;
      par_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      sout_q  <= sout_d;
      if (load) begin
        cnt_q <= '0;
        par_q <= parity_of(data_in);
      end else if (state_q == DATA && cnt_q != LAST) begin
        cnt_q <= cnt_q + 1'b1;
      end
    end
  end

  assign sout       = sout_q;
  assign load_ready = (state_q == IDLE);
  assign busy       = (state_q == START) || (state_q == DATA) ||
                      (state_q == PAR)   || (state_q == STOP);
  assign done       = (state_q == STOP);

endmodule

// File: tb/tb_serial_tx.sv
// Directed bench for serial_tx: three instances (no, even, odd parity) sharing clock and reset.
module tb_serial_tx;

  logic       clk = 1'b0;
  logic       clr;
  logic [2:0] lv;
  logic [7:0] data_in;
  logic [2:0] sout, ready, busy, done;

  int checks = 0;
  int errors = 0;
  int sel    = 0;

  logic [0:10] exp;
  logic [7:0]  pdata [3] = '{8'hA5, 8'hA5, 8'h07};
  int          psel  [3] = '{1, 2, 1};
  logic [0:10] pexp  [3] = '{11'b01010010101, 11'b01010010111, 11'b01110000011};

  always #5 clk = ~clk;

  serial_tx #(.WIDTH(8), .PARITY(0)) u0 (
    .clk(clk), .clr(clr), .load_valid(lv[0]), .load_ready(ready[0]),
    .data_in(data_in), .sout(sout[0]), .busy(busy[0]), .done(done[0]));
  serial_tx #(.WIDTH(8), .PARITY(1)) u1 (
    .clk(clk), .clr(clr), .load_valid(lv[1]), .load_ready(ready[1]),
    .data_in(data_in), .sout(sout[1]), .busy(busy[1]), .done(done[1]));
  serial_tx #(.WIDTH(8), .PARITY(2)) u2 (
    .clk(clk), .clr(clr), .load_valid(lv[2]), .load_ready(ready[2]),
    .data_in(data_in), .sout(sout[2]), .busy(busy[2]), .done(done[2]));

  task automatic test_reset();
    clr = 1'b0;
    lv = 3'b000;
    data_in = 8'h00;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      checks++;
      if (sout !== 3'b111 || ready !== 3'b111 || busy !== 3'b000 || done !== 3'b000) begin
        errors++;
        $display("FAIL reset cyc%0d: sout=%b ready=%b busy=%b done=%b, required 111/111/000/000",
                 i, sout, ready, busy, done);
      end
    end
    clr = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checks++;
      if (sout !== 3'b111 || ready !== 3'b111 || busy !== 3'b000 || done !== 3'b000) begin
        errors++;
        $display("FAIL idle cyc%0d: sout=%b ready=%b busy=%b done=%b, required 111/111/000/000",
                 i, sout, ready, busy, done);
      end
    end
  endtask

  task automatic test_basic();
    sel = 0;
    exp = {10'b0101001011, 1'b0};
    lv[sel] = 1'b1;
    data_in = 8'hA5;
    @(posedge clk);
    #1 lv[sel] = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      checks++;
      if (sout[sel] !== exp[i] || done[sel] !== logic'(i == 9) || ready[sel] !== 1'b0 || busy[sel] !== 1'b1) begin
        errors++;
        $display("FAIL basic bit%0d: sout=%b done=%b ready=%b busy=%b, required sout=%b done=%b ready=0 busy=1",
                 i, sout[sel], done[sel], ready[sel], busy[sel], exp[i], logic'(i == 9));
      end
    end
    @(negedge clk);
    checks++;
    if (sout[sel] !== 1'b1 || ready[sel] !== 1'b1 || busy[sel] !== 1'b0 || done[sel] !== 1'b0) begin
      errors++;
      $display("FAIL basic after: sout=%b ready=%b busy=%b done=%b, required 1/1/0/0",
               sout[sel], ready[sel], busy[sel], done[sel]);
    end
  endtask

  task automatic test_parity();
    for (int c = 0; c < 3; c++) begin
      sel = psel[c];
      exp = pexp[c];
      lv[sel] = 1'b1;
      data_in = pdata[c];
      @(posedge clk);
      #1 lv[sel] = 1'b0;
      for (int i = 0; i < 11; i++) begin
        @(negedge clk);
        checks++;
        if (sout[sel] !== exp[i] || done[sel] !== logic'(i == 10) || ready[sel] !== 1'b0 || busy[sel] !== 1'b1) begin
          errors++;
          $display("FAIL parity case%0d bit%0d: sout=%b done=%b ready=%b busy=%b, required sout=%b done=%b ready=0 busy=1",
                   c, i, sout[sel], done[sel], ready[sel], busy[sel], exp[i], logic'(i == 10));
        end
      end
      @(negedge clk);
      checks++;
      if (sout[sel] !== 1'b1 || ready[sel] !== 1'b1 || busy[sel] !== 1'b0) begin
        errors++;
        $display("FAIL parity case%0d after: sout=%b ready=%b busy=%b, required 1/1/0",
                 c, sout[sel], ready[sel], busy[sel]);
      end
    end
  endtask

  task automatic test_back_to_back();
    sel = 0;
    exp = {10'b0001111001, 1'b0};
    lv[sel] = 1'b1;
    data_in = 8'h3C;
    @(posedge clk);
    #1 data_in = 8'hC3;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      checks++;
      if (sout[sel] !== exp[i] || done[sel] !== logic'(i == 9) || ready[sel] !== 1'b0) begin
        errors++;
        $display("FAIL b2b first bit%0d: sout=%b done=%b ready=%b, required sout=%b done=%b ready=0",
                 i, sout[sel], done[sel], ready[sel], exp[i], logic'(i == 9));
      end
    end
    @(negedge clk);
    checks++;
    if (sout[sel] !== 1'b1 || ready[sel] !== 1'b1 || busy[sel] !== 1'b0) begin
      errors++;
      $display("FAIL b2b gap: sout=%b ready=%b busy=%b, required 1/1/0",
               sout[sel], ready[sel], busy[sel]);
    end
    @(posedge clk);
    #1 lv[sel] = 1'b0;
    data_in = 8'hFF;
    exp = {10'b0110000111, 1'b0};
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      checks++;
      if (sout[sel] !== exp[i] || done[sel] !== logic'(i == 9) || busy[sel] !== 1'b1) begin
        errors++;
        $display("FAIL b2b second bit%0d: sout=%b done=%b busy=%b, required sout=%b done=%b busy=1",
                 i, sout[sel], done[sel], busy[sel], exp[i], logic'(i == 9));
      end
    end
    @(negedge clk);
    checks++;
    if (sout[sel] !== 1'b1 || ready[sel] !== 1'b1 || busy[sel] !== 1'b0) begin
      errors++;
      $display("FAIL b2b after: sout=%b ready=%b busy=%b, required 1/1/0",
               sout[sel], ready[sel], busy[sel]);
    end
  endtask

  task automatic test_reset_mid_frame();
    sel = 0;
    exp = {10'b0000000001, 1'b0};
    lv[sel] = 1'b1;
    data_in = 8'h00;
    @(posedge clk);
    #1 lv[sel] = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checks++;
      if (sout[sel] !== exp[i] || busy[sel] !== 1'b1) begin
        errors++;
        $display("FAIL abort pre bit%0d: sout=%b busy=%b, required sout=%b busy=1",
                 i, sout[sel], busy[sel], exp[i]);
      end
    end
    #2 clr = 1'b0;
    #1;
    checks++;
    if (sout[sel] !== 1'b1 || busy[sel] !== 1'b0 || done[sel] !== 1'b0 || ready[sel] !== 1'b1) begin
      errors++;
      $display("FAIL abort immediate: sout=%b busy=%b done=%b ready=%b, required 1/0/0/1",
               sout[sel], busy[sel], done[sel], ready[sel]);
    end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if (sout[sel] !== 1'b1 || busy[sel] !== 1'b0 || done[sel] !== 1'b0) begin
        errors++;
        $display("FAIL abort held cyc%0d: sout=%b busy=%b done=%b, required 1/0/0",
                 i, sout[sel], busy[sel], done[sel]);
      end
    end
    clr = 1'b1;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      checks++;
      if (sout[sel] !== 1'b1 || busy[sel] !== 1'b0 || done[sel] !== 1'b0) begin
        errors++;
        $display("FAIL abort resume cyc%0d: sout=%b busy=%b done=%b, required 1/0/0",
                 i, sout[sel], busy[sel], done[sel]);
      end
    end
    exp = {10'b0100000011, 1'b0};
    lv[sel] = 1'b1;
    data_in = 8'h81;
    @(posedge clk);
    #1 lv[sel] = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      checks++;
      if (sout[sel] !== exp[i] || done[sel] !== logic'(i == 9)) begin
        errors++;
        $display("FAIL after abort bit%0d: sout=%b done=%b, required sout=%b done=%b",
                 i, sout[sel], done[sel], exp[i], logic'(i == 9));
      end
    end
    @(negedge clk);
  endtask

  task automatic test_ignored_request();
    sel = 0;
    exp = {10'b0010110101, 1'b0};
    lv[sel] = 1'b1;
    data_in = 8'h5A;
    @(posedge clk);
    #1 lv[sel] = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      checks++;
      if (sout[sel] !== exp[i] || done[sel] !== logic'(i == 9) || busy[sel] !== 1'b1) begin
        errors++;
        $display("FAIL ignored bit%0d: sout=%b done=%b busy=%b, required sout=%b done=%b busy=1",
                 i, sout[sel], done[sel], busy[sel], exp[i], logic'(i == 9));
      end
      if (i == 3) begin
        lv[sel] = 1'b1;
        data_in = 8'hFF;
      end
      if (i == 4) lv[sel] = 1'b0;
    end
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checks++;
      if (sout[sel] !== 1'b1 || busy[sel] !== 1'b0 || ready[sel] !== 1'b1 || done[sel] !== 1'b0) begin
        errors++;
        $display("FAIL ignored idle cyc%0d: sout=%b busy=%b ready=%b done=%b, required 1/0/1/0",
                 i, sout[sel], busy[sel], ready[sel], done[sel]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_parity();
    test_back_to_back();
    test_reset_mid_frame();
    test_ignored_request();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
